sdram_resp: RTL

SDRAM_RESP -- requirements
Module: sdram_resp

---
 rtl/sdram_pkg.sv | 46 ++++
 rtl/sdram_resp_bank.sv | 69 ++++++
 rtl/sdram_resp.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions used by the responder model and the controller:
// command encodings, mode-register fields and init FSM states.
package sdram_pkg;

    localparam int unsigned TMR_W      = 4;
    localparam int unsigned MR_CAS_LSB = 4;
    localparam int unsigned MR_CAS_MSB = 6;
    localparam int unsigned MR_BL_LSB  = 0;
    localparam int unsigned MR_BL_MSB  = 2;
    localparam int unsigned A_AP_BIT   = 10;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } cmd_t;

    typedef enum logic [2:0] {
        ST_WAIT_PC,
        ST_WAIT_REF1,
        ST_WAIT_REF2,
        ST_WAIT_MRS,
        ST_READY
    } init_state_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] data;
    } rd_slot_t;

    function automatic cmd_t decode_cmd(input logic ncs, input logic cke,
                                        input logic nras, input logic ncas, input logic nwe);
        if (ncs || !cke) return CMD_NOP;
        return cmd_t'({nras, ncas, nwe});
    endfunction

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// One SDRAM bank: open/idle state, open row, auto-precharge countdown and,
// when SDRAM_RESP_CHECK_EN is defined, the per-bank spacing timers.
module sdram_resp_bank
    import sdram_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             act,
    input  logic             pre,
    input  logic             rw,
    input  logic             ap,
    input  logic [TMR_W-1:0] ap_delay,
    input  logic [10:0]      row_in,
`ifdef SDRAM_RESP_CHECK_EN
    input  logic             wr,
    output logic [TMR_W-1:0] since_act,
    output logic [TMR_W-1:0] since_pre,
    output logic [TMR_W-1:0] since_wr,
`endif
    output logic             active,
    output logic [10:0]      row
);

    logic             active_q;
    logic             ap_pend;
    logic [TMR_W-1:0] ap_cnt;
    logic             ap_done;

    // The bank already reads as idle on the edge the countdown expires.
    assign ap_done = ap_pend && (ap_cnt == '0);
    assign active  = active_q && !ap_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q <= 1'b0;
            ap_pend  <= 1'b0;
            ap_cnt   <= '0;
            row      <= '0;
        end else if (act) begin
            active_q <= 1'b1;
            ap_pend  <= 1'b0;
            row      <= row_in;
        end else if (rw && ap) begin
            ap_pend  <= 1'b1;
            ap_cnt   <= ap_delay - 1'b1;
        end else if (pre || ap_done) begin
            active_q <= 1'b0;
            ap_pend  <= 1'b0;
        end else if (ap_pend) begin
            ap_cnt   <= ap_cnt - 1'b1;
        end
    end

`ifdef SDRAM_RESP_CHECK_EN
    // Timers hold the distance in cycles to the last event, saturating.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            since_act <= '1;
            since_pre <= '1;
            since_wr  <= '1;
        end else begin
            since_act <= act             ? TMR_W'(1) : sat_inc(since_act);
            since_pre <= (pre || ap_done) ? TMR_W'(1) : sat_inc(since_pre);
            since_wr  <= wr              ? TMR_W'(1) : sat_inc(since_wr);
        end
    end
`endif

endmodule

// File: rtl/sdram_resp.sv
// Behavioural SDRAM responder: init sequencing, four banks, byte-masked
// backing store and CAS-latency read pipeline. Checks under SDRAM_RESP_CHECK_EN.
module sdram_resp
    import sdram_pkg::*;
#(
    parameter int unsigned MEM_ADDR_BITS = 12,
    parameter int unsigned T_RCD         = 1,
    parameter int unsigned T_RP          = 1,
    parameter int unsigned T_RC          = 4,
    parameter int unsigned T_WR          = 2,
    parameter int unsigned T_MRD         = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic        SDRAM_CKE,
    input  logic [10:0] SDRAM_A,
    input  logic [1:0]  SDRAM_BA,
    input  logic [3:0]  SDRAM_DQM,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    output logic        init_done,
    output logic        err_timing,
    output logic        err_proto
);

    cmd_t                     cmd;
    init_state_t              state;
    logic [2:0]               cas;
    logic                     mrs_seen;
    logic [TMR_W-1:0]         mrd_cnt;
    logic                     ready, is_rw, do_rw, do_read, do_write, mode_ok;
    logic [TMR_W-1:0]         ap_delay;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [31:0]              rd_word;
    logic [31:0]              mem [2**MEM_ADDR_BITS];
    rd_slot_t                 pipe [3];
    logic [3:0]               b_act, b_pre, b_rw, b_active;
    logic [10:0]              b_row [4];

    assign cmd      = decode_cmd(SDRAM_nCS, SDRAM_CKE, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE);
    assign ready    = (state == ST_READY);
    assign is_rw    = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    assign do_rw    = ready && is_rw && b_active[SDRAM_BA];
    assign do_read  = do_rw && (cmd == CMD_READ);
    assign do_write = do_rw && (cmd == CMD_WRITE);
    assign mode_ok  = ((SDRAM_A[MR_CAS_MSB:MR_CAS_LSB] == 3'd2) ||
                       (SDRAM_A[MR_CAS_MSB:MR_CAS_LSB] == 3'd3)) &&
                      (SDRAM_A[MR_BL_MSB:MR_BL_LSB] == 3'd0);
    assign ap_delay = (cmd == CMD_READ) ? TMR_W'(cas) : TMR_W'(T_WR);
    assign addr     = MEM_ADDR_BITS'({SDRAM_BA, b_row[SDRAM_BA], SDRAM_A[7:0]});

`ifdef SDRAM_RESP_CHECK_EN
    logic [3:0]       b_wr;
    logic [TMR_W-1:0] since_act [4];
    logic [TMR_W-1:0] since_pre [4];
    logic [TMR_W-1:0] since_wr  [4];
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        assign b_act[gi] = ready && (cmd == CMD_ACT) && (SDRAM_BA == 2'(gi));
        assign b_pre[gi] = (cmd == CMD_PRE) && (SDRAM_A[A_AP_BIT] || (SDRAM_BA == 2'(gi)));
        assign b_rw[gi]  = do_rw && (SDRAM_BA == 2'(gi));
`ifdef SDRAM_RESP_CHECK_EN
        assign b_wr[gi]  = do_write && (SDRAM_BA == 2'(gi));
`endif
        sdram_resp_bank u_bank (
            .clk      (clk),
            .resetn   (resetn),
            .act      (b_act[gi]),
            .pre      (b_pre[gi]),
            .rw       (b_rw[gi]),
            .ap       (SDRAM_A[A_AP_BIT]),
            .ap_delay (ap_delay),
            .row_in   (SDRAM_A),
`ifdef SDRAM_RESP_CHECK_EN
            .wr       (b_wr[gi]),
            .since_act(since_act[gi]),
            .since_pre(since_pre[gi]),
            .since_wr (since_wr[gi]),
`endif
            .active   (b_active[gi]),
            .row      (b_row[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_WAIT_PC;
            cas       <= 3'd2;
            init_done <= 1'b0;
            mrs_seen  <= 1'b0;
            mrd_cnt   <= '0;
        end else begin
            if (cmd == CMD_MRS && mode_ok) cas <= SDRAM_A[MR_CAS_MSB:MR_CAS_LSB];
            case (state)
                ST_WAIT_PC:   if (cmd == CMD_PRE && SDRAM_A[A_AP_BIT]) state <= ST_WAIT_REF1;
                ST_WAIT_REF1: if (cmd == CMD_REF) state <= ST_WAIT_REF2;
                ST_WAIT_REF2: if (cmd == CMD_REF) state <= ST_WAIT_MRS;
                ST_WAIT_MRS: begin
                    if (mrs_seen) begin
                        if (mrd_cnt == '0) begin
                            state     <= ST_READY;
                            init_done <= 1'b1;
                        end else begin
                            mrd_cnt <= mrd_cnt - 1'b1;
                        end
                    end else if (cmd == CMD_MRS) begin
                        mrs_seen <= 1'b1;
                        mrd_cnt  <= TMR_W'(T_MRD - 1);
                    end
                end
                ST_READY:     init_done <= 1'b1;
                default:      state <= ST_WAIT_PC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && do_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (!SDRAM_DQM[b]) mem[addr][8*b +: 8] <= dq_in[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_word = mem[addr];
        for (int unsigned b = 0; b < 4; b++) begin
            if (SDRAM_DQM[b]) rd_word[8*b +: 8] = 8'h00;
        end
    end

    // Entry point into the 3-deep pipe is chosen so data leaves exactly CAS edges after READ.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 3; i++) pipe[i] <= '0;
            dq_oe  <= 1'b0;
            dq_out <= '0;
        end else begin
            pipe[0] <= '0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            if (do_read) begin
                if (cas == 3'd3) pipe[0] <= '{vld: 1'b1, data: rd_word};
                else             pipe[1] <= '{vld: 1'b1, data: rd_word};
            end
            dq_oe  <= pipe[2].vld;
            dq_out <= pipe[2].vld ? pipe[2].data : '0;
        end
    end

`ifdef SDRAM_RESP_CHECK_EN
    logic [TMR_W-1:0] since_ref;
    logic [3:0]       wr_recent;
    logic             proto_hit, timing_hit;

    always_comb begin
        wr_recent = '0;
        for (int unsigned i = 0; i < 4; i++) wr_recent[i] = since_wr[i] < TMR_W'(T_WR);
        proto_hit = (!ready && (cmd == CMD_ACT || is_rw))
                 || (cmd == CMD_MRS && !mode_ok)
                 || (ready && cmd == CMD_ACT && b_active[SDRAM_BA])
                 || (ready && is_rw && !b_active[SDRAM_BA])
                 || (cmd == CMD_REF && (|b_active))
                 || (cmd == CMD_WRITE && dq_oe);
        timing_hit = (do_rw && since_act[SDRAM_BA] < TMR_W'(T_RCD))
                  || (ready && cmd == CMD_ACT && since_act[SDRAM_BA] < TMR_W'(T_RC))
                  || (ready && cmd == CMD_ACT && since_pre[SDRAM_BA] < TMR_W'(T_RP))
                  || (((ready && cmd == CMD_ACT) || cmd == CMD_REF) && since_ref < TMR_W'(T_RC))
                  || (|(b_pre & wr_recent));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_timing <= 1'b0;
            err_proto  <= 1'b0;
            since_ref  <= '1;
        end else begin
            since_ref <= (cmd == CMD_REF) ? TMR_W'(1) : sat_inc(since_ref);
            if (proto_hit)  err_proto  <= 1'b1;
            if (timing_hit) err_timing <= 1'b1;
        end
    end
`else
    assign err_timing = 1'b0;
    assign err_proto  = 1'b0;
`endif

endmodule
